execute_stage_pipe: RTL and testbench

//  Parametrised, registered execute stage for the RV pipeline. Sits between
//  the decode/register-read stage and memory access.

---
 rtl/execute_stage_pipe_if.sv | 41 ++++
 rtl/execute_stage_pipe.sv | 158 +++++++++++++++
 tb/tb_execute_stage_pipe.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_pipe_if.sv
// Handshake/data bundle between the decode/register-read stage, the
// registered execute stage and the memory-access stage.
//   master : upstream/downstream side (drives op fields, in_valid, in_flush,
//            out_ready; observes in_ready and the result registers)
//   slave  : the execute stage itself
interface execute_stage_pipe_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_pc;
    logic [2:0]      in_funct3;
    logic [6:0]      in_funct7;
    logic [1:0]      in_aluop;
    logic            in_alusrc;
    logic            in_flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [XLEN-1:0] out_target;
    logic            out_zero;
    logic            out_taken;
    logic            busy;

    modport master (
        output in_valid, in_a, in_b, in_imm, in_pc, in_funct3, in_funct7,
               in_aluop, in_alusrc, in_flush, out_ready,
        input  in_ready, out_valid, out_result, out_target, out_zero,
               out_taken, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_imm, in_pc, in_funct3, in_funct7,
               in_aluop, in_alusrc, in_flush, out_ready,
        output in_ready, out_valid, out_result, out_target, out_zero,
               out_taken, busy
    );
endinterface

// File: rtl/execute_stage_pipe.sv
// Registered RV execute stage: full ALU op set, branch resolution and an
// iterative shift-add multiplier (one multiplier bit per cycle, XLEN cycles).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    execute_stage_pipe_if.slave: in_* op fields + in_valid/in_ready,
//          in_flush, out_* result registers + out_valid/out_ready, busy
module execute_stage_pipe #(
    parameter  int XLEN = 64,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    execute_stage_pipe_if.slave  bus
);
    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t          state_q;
    logic            out_valid_q;
    logic [XLEN-1:0] out_result_q;
    logic [XLEN-1:0] out_target_q;
    logic            out_zero_q;
    logic            out_taken_q;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] acc_q;
    logic [SHW-1:0]  cnt_q;

    logic [XLEN-1:0] opb;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] acc_step;
    logic            alu_taken;
    logic            lt_s, lt_u, eq;
    logic            m_ext, is_mul, accept, pop;

    // in_ready is forced low while reset is asserted even though the
    // registers already read IDLE / empty at that point.
    assign bus.in_ready = rst_n && (state_q == S_IDLE)
                          && (!out_valid_q || bus.out_ready) && !bus.in_flush;
    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = out_valid_q && bus.out_ready;

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_target = out_target_q;
    assign bus.out_zero   = out_zero_q;
    assign bus.out_taken  = out_taken_q;
    assign bus.busy       = (state_q != S_IDLE);

    assign opb   = bus.in_alusrc ? bus.in_imm : bus.in_b;
    assign shamt = opb[SHW-1:0];
    assign tgt   = bus.in_pc + (bus.in_imm << 1);
    assign lt_s  = $signed(bus.in_a) < $signed(opb);
    assign lt_u  = bus.in_a < opb;
    assign eq    = bus.in_a == opb;
    assign m_ext  = (bus.in_aluop == 2'b10) && (bus.in_funct7 == 7'b0000001);
    assign is_mul = m_ext && (bus.in_funct3 == 3'b000);

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set. Only the low XLEN bits are ever needed.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        alu_res   = '0;
        alu_taken = 1'b0;
        unique case (bus.in_aluop)
            2'b00: alu_res = bus.in_a + opb;
            2'b01: begin
                alu_res = bus.in_a - opb;
                case (bus.in_funct3)
                    3'b000:  alu_taken = eq;
                    3'b001:  alu_taken = !eq;
                    3'b100:  alu_taken = lt_s;
                    3'b101:  alu_taken = !lt_s;
                    3'b110:  alu_taken = lt_u;
                    3'b111:  alu_taken = !lt_u;
                    default: alu_taken = 1'b0;
                endcase
            end
            default: begin
                // Non-MUL M-extension encodings produce 0 in one cycle.
                if (!m_ext) begin
                    case (bus.in_funct3)
                        3'b000: alu_res = (bus.in_aluop == 2'b10 && bus.in_funct7[5])
                                          ? bus.in_a - opb : bus.in_a + opb;
                        3'b001: alu_res = bus.in_a << shamt;
                        3'b010: alu_res = {{(XLEN-1){1'b0}}, lt_s};
                        3'b011: alu_res = {{(XLEN-1){1'b0}}, lt_u};
                        3'b100: alu_res = bus.in_a ^ opb;
                        3'b101: alu_res = bus.in_funct7[5]
                                          ? $unsigned($signed(bus.in_a) >>> shamt)
                                          : bus.in_a >> shamt;
                        3'b110: alu_res = bus.in_a | opb;
                        default: alu_res = bus.in_a & opb;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_target_q <= '0;
            out_zero_q   <= 1'b0;
            out_taken_q  <= 1'b0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
        end else if (bus.in_flush) begin
            // Kill both a held result and any multiply in progress.
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else if (state_q == S_MUL) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + SHW'(1);
            if (cnt_q == SHW'(XLEN - 1)) begin
                state_q      <= S_IDLE;
                cnt_q        <= '0;
                out_result_q <= acc_step;
                out_zero_q   <= (acc_step == '0);
                out_valid_q  <= 1'b1;
            end
        end else begin
            if (pop) begin
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                // Target/taken are captured at accept for every op; for MUL
                // out_valid stays low until the product lands.
                out_target_q <= tgt;
                out_taken_q  <= alu_taken;
                if (is_mul) begin
                    state_q  <= S_MUL;
                    mcand_q  <= bus.in_a;
                    mplier_q <= opb;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                end else begin
                    out_result_q <= alu_res;
                    out_zero_q   <= (alu_res == '0);
                    out_valid_q  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_execute_stage_pipe.sv
// Scoreboard bench for execute_stage_pipe (XLEN=64): expected results are
// produced by an instruction-level reference model at accept time and
// compared by an independent monitor whenever a result is popped.
module tb_execute_stage_pipe;
    localparam int XLEN = 64;

    typedef struct {
        logic [63:0] res;
        logic [63:0] tgt;
        logic        zero;
        logic        taken;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    execute_stage_pipe_if #(.XLEN(XLEN)) bus ();
    execute_stage_pipe #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;
    bit   rand_bp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Instruction-level semantics with plain 64-bit arithmetic.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] imm, input logic [63:0] pc,
                                   input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [1:0] op, input logic src);
        exp_t e;
        logic [63:0] y;
        logic signed [63:0] sa, sy;
        int sh;
        y  = src ? imm : b;
        sa = a;
        sy = y;
        sh = int'(y[5:0]);
        e.tgt   = pc + imm * 64'd2;
        e.taken = 1'b0;
        e.res   = 64'd0;
        if (op == 2'd0) begin
            e.res = a + y;
        end else if (op == 2'd1) begin
            e.res = a - y;
            case (f3)
                3'd0: e.taken = (a == y);
                3'd1: e.taken = (a != y);
                3'd4: e.taken = (sa < sy);
                3'd5: e.taken = (sa >= sy);
                3'd6: e.taken = (a < y);
                3'd7: e.taken = (a >= y);
                default: e.taken = 1'b0;
            endcase
        end else if (op == 2'd2 && f7 == 7'd1) begin
            e.res = (f3 == 3'd0) ? a * y : 64'd0;
        end else begin
            case (f3)
                3'd0: e.res = (op == 2'd2 && f7[5]) ? a - y : a + y;
                3'd1: e.res = a << sh;
                3'd2: e.res = (sa < sy) ? 64'd1 : 64'd0;
                3'd3: e.res = (a < y) ? 64'd1 : 64'd0;
                3'd4: e.res = a ^ y;
                3'd5: e.res = f7[5] ? 64'(sa >>> sh) : a >> sh;
                3'd6: e.res = a | y;
                default: e.res = a & y;
            endcase
        end
        e.zero = (e.res == 64'd0);
        return e;
    endfunction

    // Called just after a rising edge; holds the op until it is accepted.
    task automatic drive_op(input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] imm, input logic [63:0] pc,
                            input logic [2:0] f3, input logic [6:0] f7,
                            input logic [1:0] op, input logic src);
        bit done = 1'b0;
        bus.in_a = a; bus.in_b = b; bus.in_imm = imm; bus.in_pc = pc;
        bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_aluop = op;
        bus.in_alusrc = src; bus.in_valid = 1'b1;
        if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(model(a, b, imm, pc, f3, f7, op, src));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: op not accepted, required acceptance within 200 cycles");
        end
    endtask

    // Monitor: every popped result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_txn++;
            $display("txn %0d: result=%h target=%h zero=%b taken=%b",
                     n_txn, bus.out_result, bus.out_target, bus.out_zero, bus.out_taken);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got result %h, required no output", bus.out_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", bus.out_result, e.res);
                check("target", bus.out_target, e.tgt);
                check("zero",   64'(bus.out_zero),  64'(e.zero));
                check("taken",  64'(bus.out_taken), 64'(e.taken));
            end
        end
    end

    initial begin
        int   busy_cnt;
        bit   rdy_bad;
        exp_t e;
        logic [63:0] ra, rb;
        logic [6:0]  rf7;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_flush = 1'b0; bus.out_ready = 1'b0;
        bus.in_a = '0; bus.in_b = '0; bus.in_imm = '0; bus.in_pc = '0;
        bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_aluop = '0; bus.in_alusrc = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_result",    bus.out_result,     64'd0);
        check("rst_target",    bus.out_target,     64'd0);
        check("rst_zero",      64'(bus.out_zero),  64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;

        // ADD R-type, one-cycle latency
        drive_op(64'd5, 64'd7, 64'd0, 64'd0, 3'd0, 7'd0, 2'b10, 1'b0);
        check("add_lat1_valid", 64'(bus.out_valid), 64'd1);
        check("add_lat1_result", bus.out_result, 64'd12);

        // Branches
        drive_op(64'd9, 64'd9, 64'h10, 64'h100, 3'd0, 7'd0, 2'b01, 1'b0);
        drive_op(64'd1, '1, 64'h4, 64'h200, 3'd6, 7'd0, 2'b01, 1'b0);
        drive_op(64'd1, '1, 64'h4, 64'h200, 3'd2, 7'd0, 2'b01, 1'b0);

        // MUL 3 * -2: busy exactly XLEN cycles, in_ready low throughout
        drive_op(64'd3, -64'sd2, 64'd0, 64'h40, 3'd0, 7'd1, 2'b10, 1'b0);
        busy_cnt = 0;
        rdy_bad  = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            busy_cnt++;
            if (bus.in_ready) rdy_bad = 1'b1;
        end
        bus.in_valid = 1'b0;
        check("mul_busy_cycles", 64'(busy_cnt), 64'(XLEN));
        check("mul_in_ready_low", 64'(rdy_bad), 64'd0);
        @(posedge clk); #1;

        // Backpressure: result held stable, then pop and accept together
        bus.out_ready = 1'b0;
        drive_op(64'd100, 64'd58, 64'd0, 64'd0, 3'd0, 7'h20, 2'b10, 1'b0);
        bus.in_a = 64'hF0; bus.in_b = 64'h0F; bus.in_funct3 = 3'd6; bus.in_funct7 = 7'd0;
        bus.in_aluop = 2'b10; bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_result_stable", bus.out_result, 64'd42);
            check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drive_op(64'hF0, 64'h0F, 64'd0, 64'd0, 3'd6, 7'd0, 2'b10, 1'b0);
        check("no_bubble_valid", 64'(bus.out_valid), 64'd1);
        check("no_bubble_result", bus.out_result, 64'hFF);

        // Flush at MUL step 10
        drive_op(64'd7, 64'd9, 64'd0, 64'h40, 3'd0, 7'd1, 2'b10, 1'b0);
        repeat (9) @(posedge clk);
        #1 bus.in_flush = 1'b1;
        @(posedge clk);
        #1 bus.in_flush = 1'b0;
        exp_q.delete();
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        drive_op(64'd20, 64'd22, 64'd0, 64'd0, 3'd0, 7'd0, 2'b10, 1'b0);

        // Reset mid-MUL
        drive_op(64'd11, 64'd13, 64'h8, 64'h300, 3'd0, 7'd1, 2'b10, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_target", bus.out_target, 64'd0);
        check("arst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive_op(64'h8000_0000_0000_0000, 64'd63, 64'd0, 64'd0, 3'd5, 7'h20, 2'b10, 1'b0);
        e = model(64'h8000_0000_0000_0000, 64'd63, 64'd0, 64'd0, 3'd5, 7'h20, 2'b10, 1'b0);
        check("sra_all_ones", bus.out_result, e.res);

        // Randomised ops with random backpressure
        rand_bp = 1'b1;
        for (int n = 0; n < 250; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) rb = ra;
            if ($urandom_range(0, 4) == 0) rb = 64'($urandom_range(0, 70));
            case ($urandom_range(0, 3))
                0: rf7 = 7'h00;
                1: rf7 = 7'h20;
                2: rf7 = 7'h01;
                default: rf7 = 7'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0)
                drive_op(ra, rb, {$urandom, $urandom}, {$urandom, $urandom},
                         3'd0, 7'd1, 2'b10, 1'b0);
            else
                drive_op(ra, rb, {$urandom, $urandom}, {$urandom, $urandom},
                         3'($urandom), rf7, 2'($urandom), 1'($urandom));
        end
        rand_bp = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 300 && (exp_q.size() != 0 || bus.busy); i++) @(posedge clk);
        @(negedge clk);
        check("drain_pending", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
